// File: rtl/tran_framer_pkg.sv
// rtl/tran_framer_pkg.sv - shared framer constants: command byte and FSM state encodings
package tran_framer_pkg;

   // Command byte that opens every write burst; the protocol decoder matches on it.
   localparam logic [7:0] DATA_TRAN = 8'hA5;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR_L = 3'd2;
   localparam logic [2:0] ST_ADDR_H = 3'd3;
   localparam logic [2:0] ST_LEN    = 3'd4;
   localparam logic [2:0] ST_DATA   = 3'd5;

   // States in which wide words may be taken from the word stream.
   function automatic logic is_data_phase(input logic [2:0] st);
      return (st == ST_LEN) || (st == ST_DATA);
   endfunction

endpackage

// File: rtl/tran_framer_if.sv
// rtl/tran_framer_if.sv - request, wide word and serial byte signals of the framer
interface tran_framer_if #(
   parameter int LOW_DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int HIGH_DATA_WIDTH = 32
);
   logic                       req_valid;
   logic                       req_ready;
   logic [ADDR_WIDTH-1:0]      req_addr;
   logic [7:0]                 req_len;
   logic                       word_valid;
   logic                       word_ready;
   logic [HIGH_DATA_WIDTH-1:0] word_data;
   logic                       low_write_valid;
   logic [LOW_DATA_WIDTH-1:0]  low_write_data;
   logic                       busy;
   logic                       done;
   logic                       len_err;

   modport master (
      output req_valid, req_addr, req_len, word_valid, word_data,
      input  req_ready, word_ready, low_write_valid, low_write_data, busy, done, len_err
   );

   modport slave (
      input  req_valid, req_addr, req_len, word_valid, word_data,
      output req_ready, word_ready, low_write_valid, low_write_data, busy, done, len_err
   );
endinterface

// File: rtl/tran_framer_word_serializer.sv
// rtl/tran_framer_word_serializer.sv - holds one wide word and walks its bytes LSB lane first
module tran_framer_word_serializer #(
   parameter  int LOW_DATA_WIDTH  = 8,
   parameter  int BRUST_SIZE_LOG  = 2,
   localparam int HIGH_DATA_WIDTH = LOW_DATA_WIDTH * (1 << BRUST_SIZE_LOG)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [HIGH_DATA_WIDTH-1:0] load_data,
   output logic                       empty,
   output logic                       cur_last,
   output logic                       nxt_valid,
   output logic [LOW_DATA_WIDTH-1:0]  nxt_byte,
   output logic                       nxt_last
);
   localparam int BYTES = 1 << BRUST_SIZE_LOG;
   localparam int IDX_W = (BRUST_SIZE_LOG > 0) ? BRUST_SIZE_LOG : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES - 1);
   localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(BYTES - 2);

   // active_q: a byte of the held word is on the serial bus this cycle (lane idx_q);
   // rest_q holds the lanes that follow it, next lane in the low bits.
   logic [HIGH_DATA_WIDTH-1:0] rest_q;
   logic [IDX_W-1:0]           idx_q;
   logic                       active_q;

   assign empty    = !active_q;
   assign cur_last = active_q && (idx_q == LAST_IDX);

   always_comb begin
      nxt_valid = load || (active_q && !cur_last);
      nxt_byte  = load ? load_data[LOW_DATA_WIDTH-1:0] : rest_q[LOW_DATA_WIDTH-1:0];
      nxt_last  = load ? (BYTES == 1) : (idx_q == PENULT_IDX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rest_q   <= '0;
         idx_q    <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         rest_q   <= load_data >> LOW_DATA_WIDTH;
         idx_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         if (cur_last) begin
            active_q <= 1'b0;
         end else begin
            rest_q <= rest_q >> LOW_DATA_WIDTH;
            idx_q  <= idx_q + 1'b1;
         end
      end
   end
endmodule

// File: rtl/tran_framer.sv
// rtl/tran_framer.sv - frames burst write requests into a serial byte stream
module tran_framer
   import tran_framer_pkg::*;
#(
   parameter int LOW_DATA_WIDTH = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int BRUST_SIZE_LOG = 2
) (
   input logic         clk,
   input logic         rst_n,
   tran_framer_if.slave bus
);
   localparam int HIGH_DATA_WIDTH = LOW_DATA_WIDTH * (1 << BRUST_SIZE_LOG);

   logic [2:0]                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [7:0]                 len_q;
   logic [7:0]                 words_rem, words_rem_nxt;
   logic                       req_acc, word_acc, done_nxt;
   logic                       out_valid_nxt;
   logic [LOW_DATA_WIDTH-1:0]  out_data_nxt;
   logic                       low_valid_q, busy_q, done_q, len_err_q;
   logic [LOW_DATA_WIDTH-1:0]  low_data_q;
   logic [HIGH_DATA_WIDTH-1:0] word_data;
   logic                       ser_empty, ser_cur_last, ser_nxt_valid, ser_nxt_last;
   logic [LOW_DATA_WIDTH-1:0]  ser_nxt_byte;

   assign word_data           = bus.word_data;
   assign bus.req_ready       = (state == ST_IDLE);
   assign bus.low_write_valid = low_valid_q;
   assign bus.low_write_data  = low_data_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.len_err         = len_err_q;

   assign req_acc = bus.req_valid && (state == ST_IDLE);

   // A new word may replace the held one in the same cycle its last lane is on the bus.
   assign bus.word_ready = is_data_phase(state) && (words_rem != 8'd0)
                           && (ser_empty || ser_cur_last);
   assign word_acc       = bus.word_valid && bus.word_ready;
   assign words_rem_nxt  = words_rem - {7'd0, word_acc};

   assign done_nxt = is_data_phase(state) && ser_nxt_valid && ser_nxt_last
                     && (words_rem_nxt == 8'd0);

   tran_framer_word_serializer #(
      .LOW_DATA_WIDTH (LOW_DATA_WIDTH),
      .BRUST_SIZE_LOG (BRUST_SIZE_LOG)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (word_acc),
      .load_data (word_data),
      .empty     (ser_empty),
      .cur_last  (ser_cur_last),
      .nxt_valid (ser_nxt_valid),
      .nxt_byte  (ser_nxt_byte),
      .nxt_last  (ser_nxt_last)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_acc && (bus.req_len != 8'd0)) state_nxt = ST_CMD;
         ST_CMD:    state_nxt = ST_ADDR_L;
         ST_ADDR_L: state_nxt = ST_ADDR_H;
         ST_ADDR_H: state_nxt = ST_LEN;
         ST_LEN:    state_nxt = ST_DATA;
         ST_DATA:   if (done_q) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State names the byte on the bus, so each state computes the byte for the next cycle.
   always_comb begin
      out_valid_nxt = 1'b0;
      out_data_nxt  = low_data_q;
      case (state)
         ST_IDLE: begin
            if (req_acc && (bus.req_len != 8'd0)) begin
               out_valid_nxt = 1'b1;
               out_data_nxt  = DATA_TRAN;
            end
         end
         ST_CMD: begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = addr_q[7:0];
         end
         ST_ADDR_L: begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = addr_q[15:8];
         end
         ST_ADDR_H: begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = len_q;
         end
         ST_LEN, ST_DATA: begin
            if (ser_nxt_valid) begin
               out_valid_nxt = 1'b1;
               out_data_nxt  = ser_nxt_byte;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         words_rem   <= '0;
         low_valid_q <= 1'b0;
         low_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         busy_q      <= (state_nxt != ST_IDLE);
         low_valid_q <= out_valid_nxt;
         low_data_q  <= out_data_nxt;
         done_q      <= done_nxt;
         len_err_q   <= req_acc && (bus.req_len == 8'd0);
         if (req_acc) begin
            addr_q    <= bus.req_addr;
            len_q     <= bus.req_len;
            words_rem <= bus.req_len;
         end else if (word_acc) begin
            words_rem <= words_rem_nxt;
         end
      end
   end
endmodule

// File: tb/tb_tran_framer.sv
// tb/tb_tran_framer.sv - self-checking bench for tran_framer with a byte-stream scoreboard
module tb_tran_framer;
   import tran_framer_pkg::*;

   localparam int LW = 8;
   localparam int AW = 16;
   localparam int BSL = 2;
   localparam int HW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tran_framer_if #(.LOW_DATA_WIDTH(LW), .ADDR_WIDTH(AW), .HIGH_DATA_WIDTH(HW)) bus ();

   tran_framer #(.LOW_DATA_WIDTH(LW), .ADDR_WIDTH(AW), .BRUST_SIZE_LOG(BSL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // expected serial stream, one entry per byte, with the done flag it must carry
   logic [7:0] exp_dat[$];
   bit         exp_done[$];
   // captured stream for timing checks and the decoder model
   logic [7:0] cap_dat[$];
   int         cap_cyc[$];
   // word feeder
   logic [31:0] feed_w[$];
   int          feed_at[$];
   bit          flush = 0;
   bit          hs_seen = 0;
   int          hs_count = 0;
   int          done_count = 0;
   logic [7:0]  last_dat = 8'h00;

   function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
      return seed + 32'(i) * 32'h44444444;
   endfunction

   task automatic model_push(input logic [15:0] a, input logic [7:0] l, input logic [31:0] seed);
      logic [31:0] w;
      if (l == 8'd0) return;
      exp_dat.push_back(DATA_TRAN); exp_done.push_back(0);
      exp_dat.push_back(a[7:0]);    exp_done.push_back(0);
      exp_dat.push_back(a[15:8]);   exp_done.push_back(0);
      exp_dat.push_back(l);         exp_done.push_back(0);
      for (int i = 0; i < int'(l); i++) begin
         w = word_of(seed, i);
         for (int b = 0; b < 4; b++) begin
            exp_dat.push_back(w[8*b +: 8]);
            exp_done.push_back((i == int'(l) - 1) && (b == 3));
         end
      end
   endtask

   task automatic feed_push(input logic [31:0] seed, input logic [7:0] l, input int at);
      for (int i = 0; i < int'(l); i++) begin
         feed_w.push_back(word_of(seed, i));
         feed_at.push_back(i == 0 ? at : 0);
      end
   endtask

   task automatic send_req(input logic [15:0] a, input logic [7:0] l, output int n);
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_len   = l;
      n = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            n = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (n < 0) check("req_timeout", 32'd0, 32'd1);
   endtask

   task automatic burst(input logic [15:0] a, input logic [7:0] l, input int gap,
                        input logic [31:0] seed, output int n);
      model_push(a, l, seed);
      send_req(a, l, n);
      feed_push(seed, l, n + 4 + gap);
   endtask

   task automatic wait_done(input int budget);
      int start;
      bit seen;
      start = done_count;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_count > start) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic clear_cap();
      cap_dat.delete();
      cap_cyc.delete();
   endtask

   // compare process: every cycle out of reset
   initial begin
      logic [7:0] d;
      bit e;
      forever begin
         @(negedge clk);
         hs_seen = rst_n && bus.word_valid && bus.word_ready;
         if (!rst_n) begin
            last_dat = 8'h00;
         end else begin
            if (bus.low_write_valid) begin
               if (exp_dat.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got 0x%0h at cycle %0d, no byte expected",
                           bus.low_write_data, cyc);
               end else begin
                  d = exp_dat.pop_front();
                  e = exp_done.pop_front();
                  check("stream_byte", 32'(bus.low_write_data), 32'(d));
                  check("stream_done", 32'(bus.done), 32'(e));
               end
               check("busy_with_byte", 32'(bus.busy), 32'd1);
               cap_dat.push_back(bus.low_write_data);
               cap_cyc.push_back(cyc);
               last_dat = bus.low_write_data;
            end else begin
               check("done_without_byte", 32'(bus.done), 32'd0);
               check("hold_data", 32'(bus.low_write_data), 32'(last_dat));
            end
            if (bus.done) done_count++;
         end
      end
   end

   // word feeder: presents queued words, each no earlier than its release cycle
   initial begin
      bus.word_valid = 1'b0;
      bus.word_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (flush) begin
            feed_w.delete();
            feed_at.delete();
            bus.word_valid = 1'b0;
            flush = 0;
         end else begin
            if (bus.word_valid && hs_seen) begin
               feed_w.delete(0);
               feed_at.delete(0);
               bus.word_valid = 1'b0;
               hs_count++;
            end
            if (!bus.word_valid && feed_w.size() > 0 && cyc >= feed_at[0]) begin
               bus.word_valid = 1'b1;
               bus.word_data  = feed_w[0];
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hs0, dc0, gaps;
      logic [7:0]  basic_exp [12];
      logic [15:0] lb_addr;
      logic [31:0] lb_word;

      basic_exp = '{DATA_TRAN, 8'h34, 8'h12, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'h55, 8'h66, 8'h77, 8'h88};
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(bus.low_write_valid), 32'd0);
      check("rst_data", 32'(bus.low_write_data), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_len_err", 32'(bus.len_err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_word_ready", 32'(bus.word_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // basic burst with on-time words
      clear_cap();
      burst(16'h1234, 8'd2, 0, 32'h44332211, n);
      wait_done(60);
      check("basic_ready_at_done", 32'(bus.req_ready), 32'd0);
      check("basic_busy_at_done", 32'(bus.busy), 32'd1);
      @(negedge clk); #1;
      check("basic_ready_after", 32'(bus.req_ready), 32'd1);
      check("basic_busy_after", 32'(bus.busy), 32'd0);
      check("basic_count", 32'(cap_dat.size()), 32'd12);
      if (cap_dat.size() == 12) begin
         for (int i = 0; i < 12; i++) begin
            check("basic_byte", 32'(cap_dat[i]), 32'(basic_exp[i]));
            check("basic_cycle", 32'(cap_cyc[i]), 32'(n + 1 + i));
         end
         // decoder model over the captured stream
         lb_addr = {cap_dat[2], cap_dat[1]};
         for (int w = 0; w < 2; w++) begin
            lb_word = {cap_dat[4+4*w+3], cap_dat[4+4*w+2], cap_dat[4+4*w+1], cap_dat[4+4*w]};
            check("lb_addr", 32'(lb_addr + 16'(w)), (w == 0) ? 32'h1234 : 32'h1235);
            check("lb_word", lb_word, (w == 0) ? 32'h44332211 : 32'h88776655);
         end
      end

      // five-cycle word gap after LEN
      repeat (2) @(posedge clk);
      clear_cap();
      burst(16'h00A0, 8'd1, 5, 32'h44332211, n);
      wait_done(60);
      check("gap_count", 32'(cap_dat.size()), 32'd8);
      if (cap_dat.size() == 8) begin
         check("gap_len_cycle", 32'(cap_cyc[3]), 32'(n + 4));
         check("gap_first_data", 32'(cap_cyc[4]), 32'(n + 10));
         check("gap_last_data", 32'(cap_cyc[7]), 32'(n + 13));
         check("gap_b0", 32'(cap_dat[4]), 32'h11);
         check("gap_b3", 32'(cap_dat[7]), 32'h44);
      end

      // zero-length request
      repeat (2) @(posedge clk);
      clear_cap();
      send_req(16'h5555, 8'd0, n);
      @(negedge clk); #1;
      check("zl_len_err", 32'(bus.len_err), 32'd1);
      check("zl_req_ready", 32'(bus.req_ready), 32'd1);
      check("zl_busy", 32'(bus.busy), 32'd0);
      @(negedge clk); #1;
      check("zl_len_err_end", 32'(bus.len_err), 32'd0);
      repeat (4) @(negedge clk);
      #1;
      check("zl_no_bytes", 32'(cap_dat.size()), 32'd0);

      // word offered while idle is not consumed until the burst's data phase
      hs0 = hs_count;
      feed_push(32'hDEADBEEF, 8'd1, 0);
      repeat (4) @(negedge clk);
      #1;
      check("idle_word_ready", 32'(bus.word_ready), 32'd0);
      check("idle_no_handshake", 32'(hs_count - hs0), 32'd0);
      model_push(16'h0F00, 8'd1, 32'hDEADBEEF);
      send_req(16'h0F00, 8'd1, n);
      wait_done(60);
      check("idle_word_used", 32'(hs_count - hs0), 32'd1);

      // reset after two data bytes
      repeat (2) @(posedge clk);
      clear_cap();
      burst(16'h0100, 8'd2, 0, 32'h10203040, n);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (cap_dat.size() >= 6) break;
      end
      check("mid_bytes_seen", 32'(cap_dat.size()), 32'd6);
      rst_n = 1'b0;
      #1;
      check("mid_valid", 32'(bus.low_write_valid), 32'd0);
      check("mid_data", 32'(bus.low_write_data), 32'd0);
      check("mid_busy", 32'(bus.busy), 32'd0);
      check("mid_done", 32'(bus.done), 32'd0);
      check("mid_req_ready", 32'(bus.req_ready), 32'd1);
      exp_dat.delete();
      exp_done.delete();
      flush = 1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_cap();
      burst(16'h2222, 8'd1, 0, 32'hCAFE0001, n);
      wait_done(60);
      check("restart_count", 32'(cap_dat.size()), 32'd8);
      if (cap_dat.size() == 8) begin
         check("restart_cmd_cycle", 32'(cap_cyc[0]), 32'(n + 1));
         check("restart_cmd_byte", 32'(cap_dat[0]), 32'(DATA_TRAN));
      end

      // longest burst, words back to back
      repeat (2) @(posedge clk);
      clear_cap();
      hs0 = hs_count;
      dc0 = done_count;
      burst(16'h8000, 8'd255, 0, 32'h03020100, n);
      wait_done(1200);
      repeat (3) @(negedge clk);
      #1;
      check("max_count", 32'(cap_dat.size()), 32'd1024);
      gaps = 0;
      for (int i = 0; i < cap_cyc.size(); i++)
         if (cap_cyc[i] != n + 1 + i) gaps++;
      check("max_gaps", 32'(gaps), 32'd0);
      check("max_handshakes", 32'(hs_count - hs0), 32'd255);
      check("max_done_pulses", 32'(done_count - dc0), 32'd1);

      check("stream_drained", 32'(exp_dat.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
